click_detect: RTL and testbench

Multi-channel button gesture classifier for the board's user-input path. Each channel synchronizes and debounces one raw push-button input. It then classifies each gesture as an N-click burst (single, double, triple, …) or a long press. The result is a one-cycle event pulse with a click count. The block re-arms after every event, so no reset is needed between gestures. Its outputs feed the test/demo control logic, which selects SDRAM exercise modes.

---
 rtl/click_detect.sv | 166 ++++++++++++++++
 tb/tb_click_detect.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/click_detect.sv
// Multi-channel button gesture classifier: each channel synchronizes and debounces
// one push button, then reports N-click bursts or a long press as a one-cycle event.
module click_chan #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES      = 250000,
    parameter int LONG_CYCLES     = 500000,
    parameter int MAX_CLICKS      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic       evt_valid,
    output logic       evt_long,
    output logic [2:0] evt_clicks,
    output logic       busy
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(LONG_CYCLES);

    typedef enum logic [1:0] {IDLE, DOWN, GAP, HOLD} state_t;

    logic          btn_m, btn_s, deb;
    logic [DW-1:0] deb_cnt;
    logic          settle, prs_stb, rel_stb;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    clicks, clicks_nxt;
    logic          evt_v_q, evt_v_nxt, evt_l_q, evt_l_nxt;
    logic [2:0]    evt_c_q, evt_c_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= button;
            btn_s <= btn_m;
        end
    end

    // Strobes are combinational so the FSM acts on the same edge deb flips.
    assign settle  = (btn_s != deb) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign prs_stb = settle && btn_s;
    assign rel_stb = settle && !btn_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s == deb) begin
            deb_cnt <= '0;
        end else if (settle) begin
            deb     <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            clicks  <= '0;
            evt_v_q <= 1'b0;
            evt_l_q <= 1'b0;
            evt_c_q <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            clicks  <= clicks_nxt;
            evt_v_q <= evt_v_nxt;
            evt_l_q <= evt_l_nxt;
            evt_c_q <= evt_c_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer + 1'b1;
        clicks_nxt = clicks;
        evt_v_nxt  = 1'b0;
        evt_l_nxt  = 1'b0;
        evt_c_nxt  = '0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (prs_stb) begin
                    state_nxt  = DOWN;
                    clicks_nxt = 3'd1;
                end
            end
            DOWN: begin
                if (rel_stb) begin
                    state_nxt = GAP;
                    timer_nxt = '0;
                end else if (clicks == 3'd1 && timer == TW'(LONG_CYCLES - 1)) begin
                    state_nxt = HOLD;
                    evt_v_nxt = 1'b1;
                    evt_l_nxt = 1'b1;
                    evt_c_nxt = 3'd1;
                end
            end
            GAP: begin
                // A press on the expiry edge keeps the burst alive.
                if (prs_stb) begin
                    state_nxt = DOWN;
                    timer_nxt = '0;
                    if (clicks != 3'(MAX_CLICKS))
                        clicks_nxt = clicks + 3'd1;
                end else if (timer == TW'(GAP_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    evt_v_nxt = 1'b1;
                    evt_c_nxt = clicks;
                end
            end
            HOLD: begin
                timer_nxt = timer;
                if (rel_stb)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        evt_valid  = evt_v_q;
        evt_long   = evt_l_q;
        evt_clicks = evt_c_q;
    end
endmodule

module click_detect #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES      = 250000,
    parameter int LONG_CYCLES     = 500000,
    parameter int MAX_CLICKS      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   button,
    output logic [CHANNELS-1:0]   evt_valid,
    output logic [CHANNELS-1:0]   evt_long,
    output logic [3*CHANNELS-1:0] evt_clicks,
    output logic [CHANNELS-1:0]   busy
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        click_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .GAP_CYCLES     (GAP_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .MAX_CLICKS     (MAX_CLICKS)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .button    (button[i]),
            .evt_valid (evt_valid[i]),
            .evt_long  (evt_long[i]),
            .evt_clicks(evt_clicks[3*i +: 3]),
            .busy      (busy[i])
        );
    end
endmodule

// File: tb/tb_click_detect.sv
// Randomized + directed bench for click_detect; expectations come from a
// segment-level gesture model and are checked by a decoupled monitor.
module tb_click_detect;
    localparam int CH = 2, DEB = 4, GAP = 20, LNG = 50, MAXC = 3;
    localparam int MAPN = 32768, TAIL = 45;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     button = '0;
    logic [CH-1:0]     evt_valid, evt_long, busy;
    logic [3*CH-1:0]   evt_clicks;

    click_detect #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(GAP),
        .LONG_CYCLES(LNG), .MAX_CLICKS(MAXC)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .evt_valid(evt_valid),
        .evt_long(evt_long), .evt_clicks(evt_clicks), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    typedef struct { int t; bit lng; int clicks; } exp_t;
    exp_t exp_q[CH][$];
    bit   busy_map[CH][MAPN];
    int   seg_len[CH][$];
    bit   seg_lv[CH][$];

    task automatic chk(input string nm, input int ch, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s ch%0d cyc=%0d got=%0d want=%0d", nm, ch, cyc, got, want);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes an event.
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            for (int c = 0; c < CH; c++) begin
                while (exp_q[c].size() > 0 && exp_q[c][0].t < cyc) begin
                    total++; bad++;
                    $display("FAIL missing_evt ch%0d cyc=%0d got=none want=evt@%0d", c, cyc, exp_q[c][0].t);
                    void'(exp_q[c].pop_front());
                end
                chk("busy", c, busy[c], (cyc < MAPN) ? busy_map[c][cyc] : 1'b0);
                if (evt_valid[c]) begin
                    if (exp_q[c].size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_evt ch%0d cyc=%0d got=evt want=none", c, cyc);
                    end else begin
                        e = exp_q[c].pop_front();
                        chk("evt_time", c, cyc, e.t);
                        chk("evt_long", c, evt_long[c], e.lng);
                        chk("evt_clicks", c, evt_clicks[3*c +: 3], e.clicks);
                    end
                end else begin
                    chk("idle_payload", c, {evt_long[c], evt_clicks[3*c +: 3]}, 0);
                end
            end
        end
    end

    task automatic mark_busy(input int ch, input int a, input int b);
        for (int c = a; c < b && c < MAPN; c++) busy_map[ch][c] = 1'b1;
    endtask

    task automatic push_evt(input int ch, input int t, input bit lng, input int clicks);
        exp_t e;
        e.t = t; e.lng = lng; e.clicks = clicks;
        exp_q[ch].push_back(e);
    endtask

    // Reference: raw segments -> debounced strobe times -> gestures by timing arithmetic.
    task automatic model(input int ch, input int t0, input int cutoff);
        int st[$];
        bit sl[$];
        bit deb = 0, in_g = 0, rel_ph = 0, held = 0;
        int t, clicks = 0, p_t = 0, r_t = 0, g_st = 0;
        t = t0;
        for (int i = 0; i < seg_len[ch].size(); i++) begin
            if (seg_lv[ch][i] != deb && seg_len[ch][i] >= DEB) begin
                deb = seg_lv[ch][i];
                st.push_back(t + 2 + DEB);
                sl.push_back(deb);
            end
            t += seg_len[ch][i];
        end
        for (int i = 0; i <= st.size(); i++) begin
            bit last;
            int ts;
            last = (i == st.size()) || (st[i] >= cutoff);
            ts = last ? cutoff : st[i];
            if (in_g && rel_ph && r_t + GAP < ts) begin
                if (r_t + GAP < cutoff) push_evt(ch, r_t + GAP, 1'b0, clicks);
                mark_busy(ch, g_st, r_t + GAP);
                in_g = 0;
            end
            if (in_g && !rel_ph && !held && clicks == 1 && p_t + LNG < ts) begin
                push_evt(ch, p_t + LNG, 1'b1, 1);
                held = 1;
            end
            if (last) break;
            if (sl[i]) begin
                if (!in_g) begin
                    in_g = 1; rel_ph = 0; held = 0; clicks = 1; p_t = ts; g_st = ts;
                end else begin
                    rel_ph = 0;
                    clicks = (clicks < MAXC) ? clicks + 1 : clicks;
                end
            end else if (in_g) begin
                if (held) begin
                    mark_busy(ch, g_st, ts);
                    in_g = 0;
                end else begin
                    rel_ph = 1; r_t = ts;
                end
            end
        end
        if (in_g) mark_busy(ch, g_st, cutoff);
    endtask

    task automatic clr();
        for (int c = 0; c < CH; c++) begin
            seg_len[c].delete();
            seg_lv[c].delete();
        end
    endtask

    task automatic add(input int ch, input bit lv, input int len);
        int n;
        n = seg_len[ch].size();
        if (n > 0 && seg_lv[ch][n-1] == lv) seg_len[ch][n-1] += len;
        else begin
            seg_len[ch].push_back(len);
            seg_lv[ch].push_back(lv);
        end
    endtask

    task automatic burst(input int ch, input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            add(ch, 1'b1, hi);
            add(ch, 1'b0, (k == n - 1) ? TAIL : lo);
        end
    endtask

    // Drives the current segments; rst_at>0 pulses reset on edge t0+rst_at.
    task automatic run_phase(input int rst_at);
        bit lv[CH][$];
        int t0, n, cut;
        n = 0;
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < seg_len[c].size(); i++)
                for (int k = 0; k < seg_len[c][i]; k++) lv[c].push_back(seg_lv[c][i]);
            if (lv[c].size() > n) n = lv[c].size();
        end
        if (rst_at > 0) n = rst_at;
        t0 = cyc;
        cut = (rst_at > 0) ? t0 + rst_at : MAPN;
        for (int c = 0; c < CH; c++) model(c, t0, cut);
        for (int j = 0; j < n; j++) begin
            for (int c = 0; c < CH; c++) button[c] = (j < lv[c].size()) ? lv[c][j] : 1'b0;
            if (rst_at > 0 && j == n - 1) rst = 1'b1;
            @(posedge clk); #1;
        end
        if (rst_at > 0) begin
            rst = 1'b0;
            chk("post_rst_valid", 0, evt_valid, 0);
            chk("post_rst_busy", 0, busy, 0);
            chk("post_rst_long", 0, evt_long, 0);
            chk("post_rst_clicks", 0, evt_clicks, 0);
        end
    endtask

    function automatic int rlen(input bit lv);
        case ($urandom_range(0, 3))
            0:       return $urandom_range(1, 6);
            1:       return $urandom_range(GAP - 2, GAP + 2);
            2:       return lv ? $urandom_range(LNG - 2, LNG + 2) : $urandom_range(7, 16);
            default: return $urandom_range(5, 40);
        endcase
    endfunction

    initial begin
        bit lv;
        rst = 1'b1;
        button = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 0, evt_valid, 0);
        chk("rst_busy", 0, busy, 0);
        chk("rst_long", 0, evt_long, 0);
        chk("rst_clicks", 0, evt_clicks, 0);
        rst = 1'b0;

        clr(); add(0, 1'b1, 10); add(0, 1'b0, TAIL); run_phase(0);
        clr(); burst(0, 2, 6, 8); run_phase(0);
        clr(); burst(0, 3, 6, 8); run_phase(0);
        clr(); burst(0, 5, 6, 8); burst(1, 4, 5, 12); run_phase(0);
        clr();
        for (int k = 0; k < 3; k++) begin add(0, 1'b1, 3); add(0, 1'b0, 6); end
        add(0, 1'b0, TAIL); run_phase(0);
        clr();
        add(0, 1'b1, 1); add(0, 1'b0, 1); add(0, 1'b1, 1); add(0, 1'b0, 1);
        add(0, 1'b1, 15); add(0, 1'b0, TAIL); run_phase(0);
        clr(); add(0, 1'b1, 80); add(0, 1'b0, TAIL); run_phase(0);
        clr(); add(0, 1'b1, 6); add(0, 1'b0, 8); add(0, 1'b1, 80); add(0, 1'b0, TAIL); run_phase(0);
        // Gap length equal to / one past expiry; hold equal to / one past long threshold.
        clr();
        add(0, 1'b1, 6); add(0, 1'b0, GAP); add(0, 1'b1, 6); add(0, 1'b0, TAIL);
        add(1, 1'b1, 6); add(1, 1'b0, GAP + 1); add(1, 1'b1, 6); add(1, 1'b0, TAIL);
        run_phase(0);
        clr(); add(0, 1'b1, LNG + 1); add(0, 1'b0, TAIL); add(1, 1'b1, LNG); add(1, 1'b0, TAIL);
        run_phase(0);

        clr(); add(0, 1'b1, 6); add(0, 1'b0, 60); add(1, 1'b0, 20); add(1, 1'b1, 10);
        run_phase(22);
        clr(); add(1, 1'b1, 80); add(1, 1'b0, TAIL); add(0, 1'b0, TAIL); run_phase(0);

        for (int p = 0; p < 12; p++) begin
            clr();
            for (int c = 0; c < CH; c++) begin
                lv = 1'($urandom_range(0, 1));
                for (int s = 0; s < int'($urandom_range(4, 10)); s++) begin
                    add(c, lv, rlen(lv));
                    lv = !lv;
                end
                add(c, 1'b0, TAIL);
            end
            run_phase(0);
        end

        repeat (5) @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) chk("leftover_exp", c, exp_q[c].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
